shift_sched: RTL and testbench

Scheduler for a single shared 32-bit right-shift datapath, serving two requester ports in the ALU/execute stage. It arbitrates round-robin between the two ports and implements logical right, arithmetic right and logical left shifts in one pass. Rotate-right is sequenced as two passes through the same datapath. Results are returned through a registered ready/valid output tagged with the requester index.

---
 rtl/shift_pkg.sv | 6 +
 rtl/shift_core.sv | 20 ++
 rtl/shift_sched.sv | 84 ++++++++
 tb/tb_shift_sched.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: op and state encodings shared by the shift scheduler and its datapath
package shift_pkg;
    localparam int DEF_WIDTH = 32;
    typedef enum logic [1:0] {OP_SRL = 2'b00, OP_SRA = 2'b01, OP_SLL = 2'b10, OP_ROR = 2'b11} op_t;
    typedef enum logic {S_IDLE = 1'b0, S_PASS2 = 1'b1} state_t;
endpackage

// File: rtl/shift_core.sv
// shift_core: the single shared right-shift stage with fill bit and optional bit reversal for left shifts
module shift_core import shift_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    localparam int AW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AW-1:0]    amt,
    input  logic             fill,
    input  logic             rev,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] data_rev, shin, shout, shout_rev;
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign data_rev[i]  = data[WIDTH-1-i];
        assign shout_rev[i] = shout[WIDTH-1-i];
    end
    assign shin   = rev ? data_rev : data;
    assign shout  = (shin >> amt) | (fill ? ~({WIDTH{1'b1}} >> amt) : '0);
    assign result = rev ? shout_rev : shout;
endmodule

// File: rtl/shift_sched.sv
// shift_sched: round-robin scheduler for two requesters sharing one shifter; ROR takes two passes
module shift_sched import shift_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    localparam int AW = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in0_valid,
    output logic             in0_ready,
    input  logic [WIDTH-1:0] in0_data,
    input  logic [AW-1:0]    in0_amt,
    input  logic [1:0]       in0_op,
    input  logic             in1_valid,
    output logic             in1_ready,
    input  logic [WIDTH-1:0] in1_data,
    input  logic [AW-1:0]    in1_amt,
    input  logic [1:0]       in1_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_tag
);
    state_t state, state_nx;
    logic last_grant, grant, can_accept, accept, two_pass, out_free, load_single, load_ror;
    logic core_fill, core_rev, tag_reg;
    logic [1:0] sel_op;
    logic [WIDTH-1:0] sel_data, partial, operand, core_data, core_res;
    logic [AW-1:0] sel_amt, amt_reg, core_amt;
    always_comb begin
        out_free    = !out_valid || out_ready;
        can_accept  = reset_n && state == S_IDLE && out_free;
        grant       = (in0_valid && in1_valid) ? !last_grant : in1_valid;
        in0_ready   = can_accept && !grant;
        in1_ready   = can_accept && grant;
        accept      = (in0_valid && in0_ready) || (in1_valid && in1_ready);
        sel_data    = grant ? in1_data : in0_data;
        sel_amt     = grant ? in1_amt : in0_amt;
        sel_op      = grant ? in1_op : in0_op;
        two_pass    = sel_op == OP_ROR && sel_amt != '0;
        load_single = accept && !two_pass;
        load_ror    = state == S_PASS2 && out_free;
        // pass 2 is a left shift by WIDTH-amt, which is the AW-bit negation of amt
        core_data   = state == S_PASS2 ? operand : sel_data;
        core_amt    = state == S_PASS2 ? -amt_reg : sel_amt;
        core_fill   = state == S_IDLE && sel_op == OP_SRA && sel_data[WIDTH-1];
        core_rev    = state == S_PASS2 || sel_op == OP_SLL;
        state_nx    = state == S_IDLE ? ((accept && two_pass) ? S_PASS2 : S_IDLE)
                                      : (out_free ? S_IDLE : S_PASS2);
    end
    shift_core #(.WIDTH(WIDTH)) u_core (
        .data   (core_data),
        .amt    (core_amt),
        .fill   (core_fill),
        .rev    (core_rev),
        .result (core_res)
    );
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= S_IDLE;
        else state <= state_nx;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            last_grant <= 1'b1;
            partial    <= '0;
            operand    <= '0;
            amt_reg    <= '0;
            tag_reg    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_tag    <= 1'b0;
        end else begin
            if (accept) last_grant <= grant;
            if (accept && two_pass) begin
                partial <= core_res;
                operand <= sel_data;
                amt_reg <= sel_amt;
                tag_reg <= grant;
            end
            if (load_single || load_ror) begin
                out_valid <= 1'b1;
                out_data  <= load_ror ? (partial | core_res) : core_res;
                out_tag   <= load_ror ? tag_reg : grant;
            end else if (out_ready) out_valid <= 1'b0;
        end
endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: directed vectors, corner sequences and a randomized scoreboard run for shift_sched
module tb_shift_sched;
    logic clock = 1'b0;
    logic reset_n;
    logic in0_valid, in0_ready, in1_valid, in1_ready, out_valid, out_ready, out_tag;
    logic [31:0] in0_data, in1_data, out_data;
    logic [4:0] in0_amt, in1_amt;
    logic [1:0] in0_op, in1_op;
    int total = 0, bad = 0;

    always #5 clock = ~clock;

    shift_sched #(.WIDTH(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_data(in0_data), .in0_amt(in0_amt), .in0_op(in0_op),
        .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_data(in1_data), .in1_amt(in1_amt), .in1_op(in1_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    typedef struct {
        logic        port;
        logic [1:0]  op;
        logic [31:0] data;
        logic [4:0]  amt;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic        tag;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[10];
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] d, input logic [4:0] a);
        int s;
        s = int'(a);
        case (op)
            2'd0: return d >> s;
            2'd1: return 32'($signed(d) >>> s);
            2'd2: return d << s;
            default: return (s == 0) ? d : ((d >> s) | (d << (32 - s)));
        endcase
    endfunction

    task automatic drive(input logic port, input logic [1:0] op, input logic [31:0] data, input logic [4:0] amt);
        if (port) begin
            in1_valid = 1'b1; in1_op = op; in1_data = data; in1_amt = amt;
        end else begin
            in0_valid = 1'b1; in0_op = op; in0_data = data; in0_amt = amt;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        out_ready = 1'b1;
        drive(v.port, v.op, v.data, v.amt);
        @(negedge clock);
        check({name, " ready"}, 32'(v.port ? in1_ready : in0_ready), 32'd1);
        @(posedge clock); #1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clock); #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(v.lat));
        check({name, " data"}, out_data, v.exp);
        check({name, " tag"}, 32'(out_tag), 32'(v.port));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic model_last, ror_wait, out_free, exp_can, g, acc0, acc1, p;
        logic [1:0] op;
        logic [31:0] d;
        logic [4:0] a;
        exp_t e;
        int n;

        vecs[0] = '{1'b0, 2'd0, 32'hF000_0000, 5'd4,  32'h0F00_0000, 1};
        vecs[1] = '{1'b1, 2'd1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1};
        vecs[2] = '{1'b1, 2'd2, 32'h0000_0001, 5'd31, 32'h8000_0000, 1};
        vecs[3] = '{1'b0, 2'd3, 32'h0000_00FF, 5'd8,  32'hFF00_0000, 2};
        vecs[4] = '{1'b0, 2'd3, 32'h1234_5678, 5'd0,  32'h1234_5678, 1};
        vecs[5] = '{1'b1, 2'd1, 32'h7FFF_FFFF, 5'd4,  32'h07FF_FFFF, 1};
        vecs[6] = '{1'b1, 2'd3, 32'h8000_0001, 5'd1,  32'hC000_0000, 2};
        vecs[7] = '{1'b0, 2'd2, 32'h1234_5678, 5'd0,  32'h1234_5678, 1};
        vecs[8] = '{1'b0, 2'd3, 32'h1234_5678, 5'd31, 32'h2468_ACF0, 2};
        vecs[9] = '{1'b1, 2'd2, 32'hDEAD_BEEF, 5'd16, 32'hBEEF_0000, 1};

        in0_data = '0; in1_data = '0; in0_amt = '0; in1_amt = '0; in0_op = '0; in1_op = '0;
        reset_n = 1'b0; in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b0;
        #12;
        check("rst in0_ready", 32'(in0_ready), 32'd0);
        check("rst in1_ready", 32'(in1_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", out_data, 32'd0);
        check("rst out_tag", 32'(out_tag), 32'd0);
        do_reset();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // contention: port 0 wins first after reset, then alternation with no idle cycle
        do_reset();
        drive(1'b0, 2'd0, 32'hA5A5_0000, 5'd4);
        drive(1'b1, 2'd2, 32'h0000_00F1, 5'd8);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check($sformatf("rr%0d in0_ready", k), 32'(in0_ready), 32'(k % 2 == 0));
            check($sformatf("rr%0d in1_ready", k), 32'(in1_ready), 32'(k % 2 == 1));
            if (k > 0) begin
                check($sformatf("rr%0d valid", k), 32'(out_valid), 32'd1);
                check($sformatf("rr%0d tag", k), 32'(out_tag), 32'((k - 1) % 2));
                check($sformatf("rr%0d data", k), out_data, ((k - 1) % 2) ? 32'h0000_F100 : 32'h0A5A_5000);
            end
            @(posedge clock);
        end
        #1;
        in0_valid = 1'b0; in1_valid = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 2'd1, 32'h8000_0000, 5'd4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("stall valid", 32'(out_valid), 32'd1);
            check("stall data", out_data, 32'h0000_F100);
            check("stall tag", 32'(out_tag), 32'd1);
            check("stall in0_ready", 32'(in0_ready), 32'd0);
            check("stall in1_ready", 32'(in1_ready), 32'd0);
            if (k < 2) @(posedge clock);
        end
        out_ready = 1'b1;
        #1;
        check("drain+accept ready", 32'(in0_ready), 32'd1);
        @(posedge clock); #1;
        in0_valid = 1'b0;
        check("drain+accept valid", 32'(out_valid), 32'd1);
        check("drain+accept data", out_data, 32'hF800_0000);
        check("drain+accept tag", 32'(out_tag), 32'd0);

        // reset in the middle of a rotate: the rotate must vanish
        drive(1'b0, 2'd3, 32'h0000_00FF, 5'd8);
        @(negedge clock);
        check("pre-ror ready", 32'(in0_ready), 32'd1);
        @(posedge clock); #1;
        in0_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst in0_ready", 32'(in0_ready), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("lost ror out_valid", 32'(out_valid), 32'd0);
            check("post rst in0_ready", 32'(in0_ready), 32'd1);
        end
        @(posedge clock); #1;
        run_vec(vecs[3], "ror after rst");
        run_vec(vecs[6], "ror2 after rst");

        // randomized traffic against the scoreboard
        do_reset();
        model_last = 1'b1;
        ror_wait = 1'b0;
        for (int c = 0; c < 800; c++) begin
            in0_valid = 1'($urandom_range(0, 1));
            in1_valid = 1'($urandom_range(0, 1));
            in0_data = $urandom; in1_data = $urandom;
            in0_amt = 5'($urandom_range(0, 31)); in1_amt = 5'($urandom_range(0, 31));
            in0_op = 2'($urandom_range(0, 3)); in1_op = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            out_free = !out_valid || out_ready;
            exp_can = !ror_wait && out_free;
            g = (in0_valid && in1_valid) ? !model_last : in1_valid;
            acc0 = in0_valid && in0_ready;
            acc1 = in1_valid && in1_ready;
            check("rnd one ready", 32'(in0_ready && in1_ready), 32'd0);
            if (in0_valid || in1_valid) begin
                check("rnd accept", 32'(acc0 || acc1), 32'(exp_can));
                if (acc0 || acc1) check("rnd grant", 32'(acc1), 32'(g));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("rnd spurious out", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    check("rnd data", out_data, e.data);
                    check("rnd tag", 32'(out_tag), 32'(e.tag));
                end
            end
            if (ror_wait && out_free) ror_wait = 1'b0;
            if (acc0 || acc1) begin
                p = acc1;
                op = p ? in1_op : in0_op;
                d = p ? in1_data : in0_data;
                a = p ? in1_amt : in0_amt;
                q.push_back('{p, ref_res(op, d, a)});
                model_last = p;
                if (op == 2'd3 && a != 5'd0) ror_wait = 1'b1;
            end
            @(posedge clock); #1;
        end
        in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(negedge clock);
            if (out_valid) begin
                e = q.pop_front();
                check("drain data", out_data, e.data);
                check("drain tag", 32'(out_tag), 32'(e.tag));
            end
            @(posedge clock); #1;
            n++;
        end
        check("scoreboard empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
